// File: rtl/eth_tx_src_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_src_arbiter
//
// Purpose:
//   Packet-atomic round-robin arbiter that lets NUM_SRC NoC requesters share
//   the single NoC input of the Ethernet TX tile. A packet is one header flit
//   (carrying the count of flits that follow), a meta flit, then data flits.
//   When a header transfers, the arbiter locks onto that source until the
//   packet's last flit has gone through. Packets from different sources
//   therefore never interleave at the TX tile.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   src_val    per-source flit valid
//   src_data   per-source flit data, source i at [i*DATA_W +: DATA_W]
//   src_rdy    per-source ready (only the granted source can see a 1)
//   out_val    flit valid toward the TX tile
//   out_data   flit data toward the TX tile
//   out_rdy    TX tile ready
//   busy       high while a packet body is in progress
//   grant_idx  source owning the output (BODY) or current winner (IDLE)
//   pkt_done   one-cycle pulse when the last flit of a packet transfers
// ---------------------------------------------------------------------------
module eth_tx_src_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 512,
   parameter int LEN_LSB = 0,
   parameter int LEN_W   = 8,
   parameter int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_val,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_rdy,
   output logic                      out_val,
   output logic [DATA_W-1:0]         out_data,
   input  logic                      out_rdy,
   output logic                      busy,
   output logic [SRC_W-1:0]          grant_idx,
   output logic                      pkt_done
);

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [SRC_W-1:0] lock_idx, lock_idx_nxt;
   logic [LEN_W-1:0] remain, remain_nxt;
   logic [SRC_W-1:0] winner;
   logic [SRC_W-1:0] cand_idx;
   logic [LEN_W-1:0] hdr_len;
   logic             any_val;
   logic             found;
   logic             xfer;
   int               cand;

   // Increment a source index modulo NUM_SRC. Works for non-power-of-2
   // NUM_SRC, so the pointer never lands on a nonexistent source.
   function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] idx);
      if (int'(idx) >= NUM_SRC - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   // Round-robin search starting at rr_ptr. Because rr_ptr points one past
   // the last source that finished a packet, that source ends up with the
   // lowest priority. When no source is valid, the winner defaults to rr_ptr.
   always_comb begin
      winner   = rr_ptr;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_SRC) begin
            cand = cand - NUM_SRC;
         end
         cand_idx = SRC_W'(cand);
         if (!found && src_val[cand_idx]) begin
            winner = cand_idx;
            found  = 1'b1;
         end
      end
   end

   // Zero-latency datapath. In IDLE the grant follows the live winner every
   // cycle, so a stalled header can still be overtaken. In BODY the grant is
   // pinned to the locked source, and the val of every other source is
   // ignored. Reset forces every handshake output low in the reset cycle.
   always_comb begin
      any_val   = |src_val;
      grant_idx = (state == BODY) ? lock_idx : winner;
      out_data  = src_data[int'(grant_idx)*DATA_W +: DATA_W];
      busy      = !rst && (state == BODY);
      out_val   = 1'b0;
      if (!rst) begin
         out_val = (state == BODY) ? src_val[lock_idx] : any_val;
      end
      src_rdy = '0;
      if (!rst && out_rdy && ((state == BODY) || any_val)) begin
         src_rdy[grant_idx] = 1'b1;
      end
      hdr_len = out_data[LEN_LSB +: LEN_W];
      xfer    = out_val && out_rdy;
   end

   // Next-state logic. A header with a zero length is a complete packet by
   // itself, so it never enters BODY. It still advances the round-robin
   // pointer.
   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      lock_idx_nxt = lock_idx;
      remain_nxt   = remain;
      pkt_done     = 1'b0;
      case (state)
         IDLE: begin
            if (xfer) begin
               if (hdr_len != '0) begin
                  lock_idx_nxt = winner;
                  remain_nxt   = hdr_len;
                  state_nxt    = BODY;
               end else begin
                  pkt_done   = 1'b1;
                  rr_ptr_nxt = next_src(winner);
               end
            end
         end
         BODY: begin
            if (xfer) begin
               remain_nxt = remain - 1'b1;
               if (remain == LEN_W'(1)) begin
                  pkt_done   = 1'b1;
                  rr_ptr_nxt = next_src(lock_idx);
                  state_nxt  = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State registers. Reset abandons any partial packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         lock_idx <= '0;
         remain   <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         lock_idx <= lock_idx_nxt;
         remain   <= remain_nxt;
      end
   end

endmodule

// File: tb/tb_eth_tx_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_src_arbiter
//
// Purpose:
//   Self-checking bench for eth_tx_src_arbiter (NUM_SRC=4, DATA_W=32).
//   Each source is modelled by a flit queue. Whenever a packet is queued at
//   a source, the flits the TX tile should see are pushed, in the expected
//   arbitration order, onto a scoreboard. A negedge monitor pops that
//   scoreboard on every output handshake.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_eth_tx_src_arbiter;

   localparam int NS = 4;
   localparam int DW = 32;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    src;
      logic          done;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NS-1:0]    src_val;
   logic [NS*DW-1:0] src_data;
   logic [NS-1:0]    src_rdy;
   logic             out_val;
   logic [DW-1:0]    out_data;
   logic             out_rdy;
   logic             busy;
   logic [1:0]       grant_idx;
   logic             pkt_done;

   logic [DW-1:0]    sq [NS][$];
   logic [NS-1:0]    en;
   exp_t             exp_q[$];
   exp_t             mon_e;
   int               n_cmp = 0;
   int               n_err = 0;

   eth_tx_src_arbiter #(
      .NUM_SRC(NS),
      .DATA_W (DW),
      .LEN_LSB(0),
      .LEN_W  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .src_val  (src_val),
      .src_data (src_data),
      .src_rdy  (src_rdy),
      .out_val  (out_val),
      .out_data (out_data),
      .out_rdy  (out_rdy),
      .busy     (busy),
      .grant_idx(grant_idx),
      .pkt_done (pkt_done)
   );

   always #5 clk = ~clk;

   // The watchdog keeps a broken design from hanging the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard monitor. Every output handshake must match the next expected
   // flit in data, source and pkt_done. The handshaking source's queue is
   // advanced here, which models the source pulling its next flit forward.
   always @(negedge clk) begin
      if (!rst && out_val && out_rdy) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("[TB] FAIL unexpected_xfer: got data %h src %0d expected no transfer", out_data, grant_idx);
         end else begin
            mon_e = exp_q.pop_front();
            if ({out_data, grant_idx, pkt_done} !== {mon_e.data, mon_e.src, mon_e.done}) begin
               n_err++;
               $display("[TB] FAIL flit_order: got data %h src %0d done %b expected data %h src %0d done %b",
                        out_data, grant_idx, pkt_done, mon_e.data, mon_e.src, mon_e.done);
            end
         end
         for (int i = 0; i < NS; i++) begin
            if (src_val[i] && src_rdy[i] && sq[i].size() > 0) begin
               void'(sq[i].pop_front());
            end
         end
      end
   end

   function automatic logic [DW-1:0] mk_flit(input int s, input int p, input int i, input int len);
      logic [7:0] lo;
      lo = (i == 0) ? 8'(len) : 8'hEE;
      return {8'(s), 8'(p), 8'(i), lo};
   endfunction

   // Queue a packet at source s and push its expected flits. Callers add
   // packets in the order they are expected to leave the arbiter.
   task automatic add_pkt(input int s, input int p, input int len);
      exp_t e;
      for (int i = 0; i <= len; i++) begin
         sq[s].push_back(mk_flit(s, p, i, len));
         e.data = mk_flit(s, p, i, len);
         e.src  = 2'(s);
         e.done = (i == len);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_srcs();
      for (int i = 0; i < NS; i++) begin
         if (en[i] && sq[i].size() > 0) begin
            src_val[i]           = 1'b1;
            src_data[i*DW +: DW] = sq[i][0];
         end else begin
            src_val[i]           = 1'b0;
            src_data[i*DW +: DW] = '0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive_srcs();
   endtask

   task automatic clear_all();
      for (int i = 0; i < NS; i++) begin
         sq[i].delete();
      end
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      out_rdy = 1'b0;
      en      = '1;
      clear_all();
      drive_srcs();
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Run until the scoreboard empties, counting pkt_done pulses on the way.
   task automatic drain(input int max_cyc, output int dones, output bit timed_out);
      int c;
      c     = 0;
      dones = 0;
      while (exp_q.size() > 0 && c < max_cyc) begin
         @(negedge clk);
         if (pkt_done) dones++;
         tick();
         c++;
      end
      timed_out = (exp_q.size() > 0);
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      out_rdy = 1'b1;
      en      = '1;
      clear_all();
      drive_srcs();
      tick();
      sq[2].push_back(mk_flit(2, 0, 0, 1));
      drive_srcs();
      @(negedge clk);
      n_cmp++;
      if ({out_val, src_rdy, busy, pkt_done} !== 7'b0) begin
         n_err++;
         $display("[TB] FAIL reset_outputs_with_val: got %b expected %b", {out_val, src_rdy, busy, pkt_done}, 7'b0);
      end
      tick();
      sq[2].delete();
      drive_srcs();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({out_val, src_rdy, busy, pkt_done} !== 7'b0) begin
         n_err++;
         $display("[TB] FAIL idle_no_val: got %b expected %b", {out_val, src_rdy, busy, pkt_done}, 7'b0);
      end
      tick();
   endtask

   task automatic test_single();
      int  dones;
      bit  to;
      do_reset();
      out_rdy = 1'b1;
      add_pkt(0, 1, 3);
      drive_srcs();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (src_rdy !== 4'b0001) begin
            n_err++;
            $display("[TB] FAIL single_src_rdy: got %b expected %b", src_rdy, 4'b0001);
         end
         n_cmp++;
         if ({busy, pkt_done} !== {(k != 0), (k == 3)}) begin
            n_err++;
            $display("[TB] FAIL single_busy_done: got %b expected %b", {busy, pkt_done}, {(k != 0), (k == 3)});
         end
         tick();
      end
      // Source 0 just finished, so source 1 must win over source 0 next.
      add_pkt(1, 2, 0);
      add_pkt(0, 2, 0);
      drive_srcs();
      @(negedge clk);
      n_cmp++;
      if ({grant_idx, src_rdy} !== {2'd1, 4'b0010}) begin
         n_err++;
         $display("[TB] FAIL rr_after_src0: got %h expected %h", {grant_idx, src_rdy}, {2'd1, 4'b0010});
      end
      tick();
      drain(20, dones, to);
      n_cmp++;
      if (to) begin
         n_err++;
         $display("[TB] FAIL single_drain: got %0d left expected 0", exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      int  dones;
      bit  to;
      do_reset();
      out_rdy = 1'b1;
      add_pkt(0, 10, 2);
      add_pkt(1, 11, 2);
      add_pkt(2, 12, 2);
      add_pkt(3, 13, 2);
      add_pkt(0, 14, 2);
      drive_srcs();
      drain(60, dones, to);
      n_cmp++;
      if (to || dones != 5) begin
         n_err++;
         $display("[TB] FAIL rr_packets: got %0d done (timeout %b) expected 5", dones, to);
      end
   endtask

   task automatic test_lockout();
      int  dones;
      bit  to;
      do_reset();
      out_rdy = 1'b1;
      en      = 4'b0010;
      add_pkt(1, 20, 2);
      drive_srcs();
      @(negedge clk);
      tick();
      en[2] = 1'b1;
      add_pkt(2, 21, 0);
      drive_srcs();
      @(negedge clk);
      n_cmp++;
      if ({grant_idx, src_rdy, busy} !== {2'd1, 4'b0010, 1'b1}) begin
         n_err++;
         $display("[TB] FAIL lock_mid: got %h expected %h", {grant_idx, src_rdy, busy}, {2'd1, 4'b0010, 1'b1});
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if ({src_rdy, pkt_done} !== {4'b0010, 1'b1}) begin
         n_err++;
         $display("[TB] FAIL lock_last: got %b expected %b", {src_rdy, pkt_done}, {4'b0010, 1'b1});
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if ({grant_idx, src_rdy} !== {2'd2, 4'b0100}) begin
         n_err++;
         $display("[TB] FAIL lock_handover: got %h expected %h", {grant_idx, src_rdy}, {2'd2, 4'b0100});
      end
      tick();
      drain(20, dones, to);
      n_cmp++;
      if (to) begin
         n_err++;
         $display("[TB] FAIL lock_drain: got %0d left expected 0", exp_q.size());
      end
   endtask

   task automatic test_stall();
      int xfers;
      do_reset();
      xfers = 0;
      add_pkt(0, 30, 5);
      drive_srcs();
      for (int c = 0; c < 12; c++) begin
         out_rdy = (c % 2 == 0);
         @(negedge clk);
         if (out_val && out_rdy) xfers++;
         n_cmp++;
         if (src_rdy !== (out_rdy ? 4'b0001 : 4'b0000)) begin
            n_err++;
            $display("[TB] FAIL stall_src_rdy: got %b expected %b", src_rdy, (out_rdy ? 4'b0001 : 4'b0000));
         end
         tick();
      end
      n_cmp++;
      if (xfers != 6 || exp_q.size() != 0) begin
         n_err++;
         $display("[TB] FAIL stall_xfers: got %0d (left %0d) expected 6 (left 0)", xfers, exp_q.size());
      end
   endtask

   task automatic test_zero_len();
      int  dones;
      bit  to;
      do_reset();
      out_rdy = 1'b1;
      add_pkt(3, 40, 0);
      drive_srcs();
      @(negedge clk);
      n_cmp++;
      if ({grant_idx, pkt_done, busy} !== {2'd3, 1'b1, 1'b0}) begin
         n_err++;
         $display("[TB] FAIL zero_len_hdr: got %b expected %b", {grant_idx, pkt_done, busy}, {2'd3, 1'b1, 1'b0});
      end
      tick();
      // The pointer must wrap from source 3 back to source 0.
      add_pkt(0, 41, 0);
      add_pkt(1, 41, 0);
      add_pkt(2, 41, 0);
      add_pkt(3, 41, 0);
      drive_srcs();
      @(negedge clk);
      n_cmp++;
      if ({grant_idx, busy} !== {2'd0, 1'b0}) begin
         n_err++;
         $display("[TB] FAIL zero_len_wrap: got %b expected %b", {grant_idx, busy}, {2'd0, 1'b0});
      end
      tick();
      drain(20, dones, to);
      n_cmp++;
      if (to || dones != 3) begin
         n_err++;
         $display("[TB] FAIL zero_len_drain: got %0d done (timeout %b) expected 3", dones, to);
      end
   endtask

   task automatic test_reset_mid();
      int  dones;
      bit  to;
      do_reset();
      out_rdy = 1'b1;
      add_pkt(1, 50, 0);
      drive_srcs();
      @(negedge clk);
      tick();
      add_pkt(0, 51, 4);
      drive_srcs();
      @(negedge clk);
      n_cmp++;
      if (grant_idx !== 2'd0) begin
         n_err++;
         $display("[TB] FAIL mid_hdr_grant: got %0d expected 0", grant_idx);
      end
      tick();
      rst = 1'b1;
      clear_all();
      drive_srcs();
      @(negedge clk);
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({out_val, busy, src_rdy} !== 6'b0) begin
         n_err++;
         $display("[TB] FAIL mid_after_reset: got %b expected %b", {out_val, busy, src_rdy}, 6'b0);
      end
      tick();
      add_pkt(1, 52, 0);
      add_pkt(2, 53, 1);
      drive_srcs();
      @(negedge clk);
      n_cmp++;
      if (grant_idx !== 2'd1) begin
         n_err++;
         $display("[TB] FAIL mid_rr_cleared: got %0d expected 1", grant_idx);
      end
      tick();
      drain(20, dones, to);
      n_cmp++;
      if (to || dones != 1) begin
         n_err++;
         $display("[TB] FAIL mid_new_pkt: got %0d done (timeout %b) expected 1", dones, to);
      end
   endtask

   initial begin
      rst      = 1'b1;
      out_rdy  = 1'b0;
      en       = '1;
      src_val  = '0;
      src_data = '0;
      $display("[TB] starting eth_tx_src_arbiter bench");
      test_reset();
      test_single();
      test_round_robin();
      test_lockout();
      test_stall();
      test_zero_len();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
